// File: rtl/guarded_array_writer_if.sv
// guarded_array_writer_if
// Bundles the write-request handshake and the registered read port of
// guarded_array_writer.
//   wr_valid / wr_ready : write request handshake (ready is low while committing)
//   wr_idx / wr_data    : write request index and payload
//   rd_idx              : read index, sampled every cycle
//   rd_data / rd_err    : registered read result, one cycle after rd_idx
// Modports: master drives requests and reads, slave is the array itself.
interface guarded_array_writer_if #(
    parameter int WIDTH = 2,
    parameter int IDXW  = 4
);
    logic             wr_valid;
    logic             wr_ready;
    logic [IDXW-1:0]  wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic [IDXW-1:0]  rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic             rd_err;

    modport master (
        output wr_valid, wr_idx, wr_data, rd_idx,
        input  wr_ready, rd_data, rd_err
    );

    modport slave (
        input  wr_valid, wr_idx, wr_data, rd_idx,
        output wr_ready, rd_data, rd_err
    );
endinterface

// File: rtl/guarded_array_writer.sv
// guarded_array_writer
// A small register array whose writes are index-checked. A write request is
// captured in IDLE and committed one cycle later (COMMIT); an out-of-range or
// unknown index is dropped and reported through err_pulse / err_cnt. Reads are
// registered with one cycle of latency and see the pre-commit value when they
// coincide with a commit. An optional override can pin one slot so that reads
// of it return a fixed value while writes still land in the underlying storage.
//
// Optional feature macro: GUARDED_ARRAY_OVERRIDE_EN
//   defined   : ovr_set / ovr_clr / ovr_idx / ovr_data pin one slot
//   undefined : the ovr_* ports exist but are ignored
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset, overrides every other input
//   bus        : guarded_array_writer_if.slave (write handshake + read port)
//   ovr_set    : pin slot ovr_idx to ovr_data (set wins over a same-cycle clear)
//   ovr_clr    : release the pinned slot
//   ovr_idx    : index of the slot to pin
//   ovr_data   : value returned by reads of the pinned slot
//   err_pulse  : high in any cycle that rejects a write commit or an override
//   err_cnt    : saturating count of rejected events
module guarded_array_writer #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2,
    parameter int BASE  = 1,
    parameter int IDXW  = 4,
    parameter int CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    guarded_array_writer_if.slave bus,
    input  logic                  ovr_set,
    input  logic                  ovr_clr,
    input  logic [IDXW-1:0]       ovr_idx,
    input  logic [WIDTH-1:0]      ovr_data,
    output logic                  err_pulse,
    output logic [CNTW-1:0]       err_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so BASE+DEPTH-1 cannot wrap against an IDXW-bit index.
    localparam logic [IDXW:0] IDX_LO = (IDXW+1)'(BASE);
    localparam logic [IDXW:0] IDX_HI = (IDXW+1)'(BASE + DEPTH - 1);

    // An index is usable only when fully known and inside BASE..BASE+DEPTH-1.
    function automatic logic idx_ok(input logic [IDXW-1:0] idx);
        return !$isunknown(idx) && ({1'b0, idx} >= IDX_LO) && ({1'b0, idx} <= IDX_HI);
    endfunction

    function automatic logic [AW-1:0] slot_of(input logic [IDXW-1:0] idx);
        return AW'({1'b0, idx} - IDX_LO);
    endfunction

    // Adds 0..2 rejected events and clamps at all-ones.
    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a,
                                                input logic [1:0]      b);
        logic [CNTW:0] s;
        s = {1'b0, a} + {{(CNTW-1){1'b0}}, b};
        return s[CNTW] ? {CNTW{1'b1}} : s[CNTW-1:0];
    endfunction

    typedef enum logic {IDLE = 1'b0, COMMIT = 1'b1} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             cap_ok_p1;
    logic [AW-1:0]    cap_slot_p1;
    logic [WIDTH-1:0] cap_data_p1;

    logic             rej_wr;
    logic             rej_ovr;
    logic             ovr_active;
    logic [AW-1:0]    ovr_slot;
    logic [WIDTH-1:0] ovr_val;

    // ---- capture stage (IDLE) -> commit stage (COMMIT) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.wr_ready <= 1'b1;
            cap_ok_p1    <= 1'b0;
            cap_slot_p1  <= '0;
            cap_data_p1  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr_valid) begin
                        state        <= COMMIT;
                        bus.wr_ready <= 1'b0;
                        cap_ok_p1    <= idx_ok(bus.wr_idx);
                        cap_slot_p1  <= slot_of(bus.wr_idx);
                        cap_data_p1  <= bus.wr_data;
                    end
                end
                COMMIT: begin
                    if (cap_ok_p1) begin
                        mem[cap_slot_p1] <= cap_data_p1;
                    end
                    state        <= IDLE;
                    bus.wr_ready <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    bus.wr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign rej_wr = (state == COMMIT) && !cap_ok_p1;

`ifdef GUARDED_ARRAY_OVERRIDE_EN
    logic ovr_ok;
    assign ovr_ok  = idx_ok(ovr_idx);
    assign rej_ovr = ovr_set && !ovr_ok;

    // Clear is applied first so a simultaneous valid set ends up active.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_active <= 1'b0;
            ovr_slot   <= '0;
            ovr_val    <= '0;
        end else begin
            if (ovr_clr) begin
                ovr_active <= 1'b0;
            end
            if (ovr_set && ovr_ok) begin
                ovr_active <= 1'b1;
                ovr_slot   <= slot_of(ovr_idx);
                ovr_val    <= ovr_data;
            end
        end
    end
`else
    logic ovr_unused;
    assign ovr_unused = ^{ovr_set, ovr_clr, ovr_idx, ovr_data};
    assign rej_ovr    = 1'b0;
    assign ovr_active = 1'b0;
    assign ovr_slot   = '0;
    assign ovr_val    = '0;
`endif

    // A commit-cycle write reject and an override reject may coincide.
    assign err_pulse = !rst && (rej_wr || rej_ovr);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (rej_wr || rej_ovr) begin
            err_cnt <= sat_add(err_cnt, {rej_wr & rej_ovr, rej_wr ^ rej_ovr});
        end
    end

    // ---- read stage: rd_idx -> rd_data / rd_err ----
    // mem is sampled before this edge's commit lands, giving read-before-write.
    logic          rd_ok;
    logic [AW-1:0] rd_slot;
    assign rd_ok   = idx_ok(bus.rd_idx);
    assign rd_slot = slot_of(bus.rd_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data <= '0;
            bus.rd_err  <= 1'b0;
        end else if (!rd_ok) begin
            bus.rd_data <= '0;
            bus.rd_err  <= 1'b1;
        end else begin
            bus.rd_err  <= 1'b0;
            if (ovr_active && (ovr_slot == rd_slot)) begin
                bus.rd_data <= ovr_val;
            end else begin
                bus.rd_data <= mem[rd_slot];
            end
        end
    end

endmodule

// File: tb/tb_guarded_array_writer.sv
// tb_guarded_array_writer
// Randomized and directed stimulus for guarded_array_writer, checked against a
// behavioural model of the array, override and error counter kept here.
// The override expectations follow GUARDED_ARRAY_OVERRIDE_EN, so the same bench
// serves both builds.
module tb_guarded_array_writer;

    localparam int W  = 2;
    localparam int D  = 2;
    localparam int B  = 1;
    localparam int IW = 4;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;
`ifdef GUARDED_ARRAY_OVERRIDE_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ovr_set = 1'b0;
    logic          ovr_clr = 1'b0;
    logic [IW-1:0] ovr_idx = '0;
    logic [W-1:0]  ovr_data = '0;
    logic          err_pulse;
    logic [CW-1:0] err_cnt;

    guarded_array_writer_if #(.WIDTH(W), .IDXW(IW)) bus ();

    guarded_array_writer #(
        .WIDTH(W), .DEPTH(D), .BASE(B), .IDXW(IW), .CNTW(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ovr_set  (ovr_set),
        .ovr_clr  (ovr_clr),
        .ovr_idx  (ovr_idx),
        .ovr_data (ovr_data),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: logical array indexed by legal index, plus override.
    int m_mem [D];
    bit m_act;
    int m_oidx;
    int m_odata;
    int m_cnt;

    function automatic bit m_valid(input logic [IW-1:0] idx);
        int v;
        if ($isunknown(idx)) return 1'b0;
        v = int'(idx);
        return (v >= B) && (v < B + D);
    endfunction

    function automatic int m_read(input logic [IW-1:0] idx);
        if (!m_valid(idx)) return 0;
        if (m_act && (m_oidx == int'(idx))) return m_odata;
        return m_mem[int'(idx) - B];
    endfunction

    function automatic void m_err(input int n);
        m_cnt = (m_cnt + n > CMAX) ? CMAX : m_cnt + n;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < D; i++) m_mem[i] = 0;
        m_act = 1'b0; m_oidx = 0; m_odata = 0; m_cnt = 0;
    endfunction

    function automatic void m_ovr(input bit set, input bit clr,
                                  input logic [IW-1:0] idx, input int data);
        if (!OVR_EN) return;
        if (clr) m_act = 1'b0;
        if (set && m_valid(idx)) begin
            m_act = 1'b1; m_oidx = int'(idx); m_odata = data;
        end
    endfunction

    // One write transaction; optionally an invalid override in the commit cycle.
    task automatic do_write(input logic [IW-1:0] idx, input logic [W-1:0] data, input bit ovr_bad);
        int t = 0;
        bit exp_p;
        while (bus.wr_ready !== 1'b1 && t < 8) begin
            @(posedge clk); #1; t++;
        end
        n_checks++;
        if (bus.wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_ready_idle: got %b want 1", bus.wr_ready);
        end
        bus.wr_valid = 1'b1; bus.wr_idx = idx; bus.wr_data = data;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        if (ovr_bad) begin
            ovr_set = 1'b1; ovr_idx = '0; ovr_data = '0;
        end
        #1;
        exp_p = !m_valid(idx) || (OVR_EN && ovr_bad);
        n_checks++;
        if (bus.wr_ready !== 1'b0) begin
            n_fail++; $display("FAIL wr_ready_commit: got %b want 0", bus.wr_ready);
        end
        n_checks++;
        if (err_pulse !== exp_p) begin
            n_fail++; $display("FAIL err_pulse_commit idx=%0d: got %b want %b", idx, err_pulse, exp_p);
        end
        @(posedge clk); #1;
        ovr_set = 1'b0;
        if (m_valid(idx)) m_mem[int'(idx) - B] = int'(data);
        m_err(int'(!m_valid(idx)) + int'(OVR_EN && ovr_bad));
        n_checks++;
        if (err_cnt !== CW'(m_cnt)) begin
            n_fail++; $display("FAIL err_cnt_write idx=%0d: got %0d want %0d", idx, err_cnt, m_cnt);
        end
        n_checks++;
        if (bus.wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_ready_after: got %b want 1", bus.wr_ready);
        end
    endtask

    task automatic do_read(input logic [IW-1:0] idx);
        int e;
        bit ee;
        bus.rd_idx = idx;
        e  = m_read(idx);
        ee = !m_valid(idx);
        @(posedge clk); #1;
        n_checks++;
        if (bus.rd_data !== W'(e)) begin
            n_fail++; $display("FAIL rd_data idx=%0d: got %0d want %0d", idx, bus.rd_data, e);
        end
        n_checks++;
        if (bus.rd_err !== ee) begin
            n_fail++; $display("FAIL rd_err idx=%0d: got %b want %b", idx, bus.rd_err, ee);
        end
    endtask

    task automatic do_ovr(input bit set, input bit clr, input logic [IW-1:0] idx, input logic [W-1:0] data);
        bit exp_p;
        ovr_set = set; ovr_clr = clr; ovr_idx = idx; ovr_data = data;
        #1;
        exp_p = OVR_EN && set && !m_valid(idx);
        n_checks++;
        if (err_pulse !== exp_p) begin
            n_fail++; $display("FAIL err_pulse_ovr idx=%0d: got %b want %b", idx, err_pulse, exp_p);
        end
        @(posedge clk); #1;
        ovr_set = 1'b0; ovr_clr = 1'b0;
        m_ovr(set, clr, idx, int'(data));
        if (OVR_EN && set && !m_valid(idx)) m_err(1);
        n_checks++;
        if (err_cnt !== CW'(m_cnt)) begin
            n_fail++; $display("FAIL err_cnt_ovr: got %0d want %0d", err_cnt, m_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_reset();
        n_checks++;
        if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); end
        n_checks++;
        if (bus.rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %0d want 0", bus.rd_data); end
        n_checks++;
        if (bus.rd_err !== 1'b0) begin n_fail++; $display("FAIL reset_rd_err: got %b want 0", bus.rd_err); end
        n_checks++;
        if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
        n_checks++;
        if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        rst = 1'b0;
        do_read(IW'(1));
        do_read(IW'(2));
    endtask

    task automatic test_basic_write();
        do_write(IW'(1), 2'd3, 1'b0);
        do_write(IW'(2), 2'd2, 1'b0);
        do_read(IW'(1));
        do_read(IW'(2));
    endtask

    task automatic test_invalid_write();
        do_write(IW'(0), 2'd1, 1'b0);
        do_write(IW'(3), 2'd1, 1'b0);
        do_read(IW'(1));
        do_read(IW'(2));
        do_write('x, 2'd1, 1'b0);
        do_read('x);
        do_read(IW'(15));
    endtask

    task automatic test_read_before_write();
        int old_v;
        int new_v;
        old_v = m_read(IW'(1));
        new_v = (old_v + 1) % (1 << W);
        bus.wr_valid = 1'b1; bus.wr_idx = IW'(1); bus.wr_data = W'(new_v);
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        bus.rd_idx = IW'(1);
        @(posedge clk); #1;
        n_checks++;
        if (bus.rd_data !== W'(old_v)) begin
            n_fail++; $display("FAIL read_before_write: got %0d want %0d", bus.rd_data, old_v);
        end
        m_mem[0] = new_v;
        do_read(IW'(1));
    endtask

    task automatic test_override();
        do_ovr(1'b1, 1'b0, IW'(2), 2'd1);
        do_write(IW'(2), 2'd0, 1'b0);
        do_read(IW'(2));
        do_ovr(1'b0, 1'b1, IW'(0), 2'd0);
        do_read(IW'(2));
        do_ovr(1'b0, 1'b1, IW'(0), 2'd0);
        do_read(IW'(2));
        do_ovr(1'b1, 1'b0, IW'(1), 2'd1);
        do_ovr(1'b1, 1'b0, IW'(2), 2'd3);
        do_read(IW'(1));
        do_read(IW'(2));
        do_ovr(1'b0, 1'b1, IW'(0), 2'd0);
    endtask

    task automatic test_override_invalid();
        do_ovr(1'b1, 1'b0, 'x, 2'd1);
        do_read(IW'(1));
        do_read(IW'(2));
        do_ovr(1'b1, 1'b1, IW'(1), 2'd2);
        do_read(IW'(1));
        do_write(IW'(0), 2'd1, 1'b1);
        do_write(IW'(1), 2'd0, 1'b1);
        do_read(IW'(1));
        do_ovr(1'b0, 1'b1, IW'(0), 2'd0);
        do_read(IW'(1));
    endtask

    task automatic test_random();
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 3))
                0, 1: do_write(IW'($urandom_range(0, 4)), W'($urandom_range(0, 3)),
                               $urandom_range(0, 3) == 0);
                2:    do_read(IW'($urandom_range(0, 4)));
                default: do_ovr($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                IW'($urandom_range(0, 4)), W'($urandom_range(0, 3)));
            endcase
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 300; k++) begin
            do_write(IW'(0), 2'd1, 1'b0);
        end
        n_checks++;
        if (err_cnt !== CW'(CMAX)) begin
            n_fail++; $display("FAIL err_cnt_saturate: got %0d want %0d", err_cnt, CMAX);
        end
    endtask

    task automatic test_reset_mid_commit();
        // Invalid write and an override request both land on a reset cycle.
        bus.wr_valid = 1'b1; bus.wr_idx = IW'(0); bus.wr_data = 2'd1;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        rst = 1'b1; ovr_set = 1'b1; ovr_idx = IW'(1); ovr_data = 2'd3;
        #1;
        n_checks++;
        if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_err_pulse: got %b want 0", err_pulse); end
        @(posedge clk); #1;
        rst = 1'b0; ovr_set = 1'b0;
        m_reset();
        n_checks++;
        if (err_cnt !== '0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
        n_checks++;
        if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %b want 1", bus.wr_ready); end
        do_read(IW'(1));
        // Valid write discarded by reset during its commit.
        bus.wr_valid = 1'b1; bus.wr_idx = IW'(2); bus.wr_data = 2'd3;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        do_read(IW'(2));
        n_checks++;
        if (err_cnt !== '0) begin n_fail++; $display("FAIL rst_err_cnt2: got %0d want 0", err_cnt); end
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_idx   = '0;
        bus.wr_data  = '0;
        bus.rd_idx   = '0;
        m_reset();
        test_reset();
        test_basic_write();
        test_read_before_write();
        test_invalid_write();
        test_override();
        test_override_invalid();
        test_random();
        test_saturate();
        test_reset_mid_commit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
